// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM stage: load types, store masks, FSM state type
// and the alignment rule used by the access unit and forwarding checks.
package riscv_mem_pkg;

   typedef logic [2:0] load_type_t;
   localparam load_type_t LT_NONE = 3'd0;
   localparam load_type_t LT_LB   = 3'd1;
   localparam load_type_t LT_LH   = 3'd2;
   localparam load_type_t LT_LW   = 3'd3;
   localparam load_type_t LT_LBU  = 3'd4;
   localparam load_type_t LT_LHU  = 3'd5;

   localparam logic [3:0] SB_MASK = 4'b0001;
   localparam logic [3:0] SH_MASK = 4'b0011;
   localparam logic [3:0] SW_MASK = 4'b1111;

   typedef logic [0:0] mem_state_t;
   localparam mem_state_t ST_IDLE   = 1'b0;
   localparam mem_state_t ST_ACCESS = 1'b1;

   // Loads are classified by load type, stores by their byte mask.
   function automatic logic is_misaligned(input logic is_load, input load_type_t lt,
                                          input logic [3:0] mask, input logic [1:0] off);
      logic is_half;
      logic is_word;
      is_half = is_load ? (lt == LT_LH || lt == LT_LHU) : (mask == SH_MASK);
      is_word = is_load ? (lt == LT_LW) : (mask == SW_MASK);
      return (is_half && off[0]) || (is_word && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the SoC
// memory (slave).
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   // Handshake: the master raises bus_req with bus_addr/bus_we/bus_wdata and
   // holds all of them stable until the slave returns a one-cycle bus_ack;
   // bus_rdata is valid only in the ack cycle. bus_we == 0 means read.
   logic              bus_req;
   logic [3:0]        bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic              bus_ack;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word lane of a read word and sign- or
// zero-extends it according to the load type.
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  load_type_t  load_type,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[8*offset +: 8];
      half_lane = rdata[16*offset[1] +: 16];
      case (load_type)
         LT_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         LT_LH:   result = {{16{half_lane[15]}}, half_lane};
         LT_LBU:  result = {24'd0, byte_lane};
         LT_LHU:  result = {16'd0, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access engine: runs loads/stores on the req/ack bus, stalls the
// pipeline while an access is outstanding and registers the MEM/WB result.
// Optional bus watchdog with BusErrM output: define MEM_TIMEOUT_EN.
module mem_access_unit
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       PC_MEM,
   input  logic [31:0]       AluOutM,
   input  logic [31:0]       StoreDataM,
   input  logic [4:0]        RdM,
   input  logic [2:0]        RegWriteM,
   input  logic              MemToRegM,
   input  logic [3:0]        MemWriteM,
   input  logic              LoadNpcM,
   mem_access_unit_if.master bus,
   output logic              StallM,
   output logic              MisalignM,
   output logic [31:0]       ResultW,
   output logic [4:0]        RdW,
   output logic              RegWriteW,
`ifdef MEM_TIMEOUT_EN
   output logic              BusErrM,
`endif
   output mem_state_t        state_dbg
);

   mem_state_t  state;
   load_type_t  lt_q;
   logic [1:0]  off_q;
   logic        load_q;
   logic        mem_op;
   logic        misaligned;
   logic        timeout_hit;
   logic [31:0] load_result;

   assign mem_op     = MemToRegM | (|MemWriteM);
   assign misaligned = is_misaligned(MemToRegM, RegWriteM, MemWriteM, AluOutM[1:0]);
   assign state_dbg  = state;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wd_cnt;

   assign timeout_hit = (state == ST_ACCESS) && !bus.bus_ack &&
                        (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counter sits at zero in IDLE, so it is clear on every entry to ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt  <= '0;
         BusErrM <= 1'b0;
      end else begin
         BusErrM <= timeout_hit;
         if (state == ST_IDLE) wd_cnt <= '0;
         else if (!bus.bus_ack) wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Stall drops in the completing cycle so EX/MEM advances with the WB capture.
   always_comb begin
      StallM = 1'b0;
      case (state)
         ST_IDLE:   StallM = mem_op & ~misaligned;
         ST_ACCESS: StallM = ~(bus.bus_ack | timeout_hit);
         default:   StallM = 1'b0;
      endcase
   end

   load_extend u_load_extend (
      .rdata     (bus.bus_rdata),
      .offset    (off_q),
      .load_type (lt_q),
      .result    (load_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 4'b0000;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= 32'd0;
         MisalignM     <= 1'b0;
         ResultW       <= 32'd0;
         RdW           <= 5'd0;
         RegWriteW     <= 1'b0;
         lt_q          <= LT_NONE;
         off_q         <= 2'b00;
         load_q        <= 1'b0;
      end else begin
         MisalignM <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_op) begin
                  RegWriteW <= 1'b0;
                  if (misaligned) begin
                     MisalignM <= 1'b1;
                  end else begin
                     state         <= ST_ACCESS;
                     bus.bus_req   <= 1'b1;
                     bus.bus_addr  <= ADDR_W'({AluOutM[31:2], 2'b00});
                     bus.bus_we    <= MemWriteM << AluOutM[1:0];
                     bus.bus_wdata <= StoreDataM << {AluOutM[1:0], 3'b000};
                     lt_q          <= RegWriteM;
                     off_q         <= AluOutM[1:0];
                     load_q        <= MemToRegM;
                  end
               end else begin
                  ResultW   <= LoadNpcM ? (PC_MEM + 32'd4) : AluOutM;
                  RdW       <= RdM;
                  RegWriteW <= (RegWriteM >= LT_LB) && (RegWriteM <= LT_LHU) && (RdM != 5'd0);
               end
            end
            ST_ACCESS: begin
               // EX/MEM is frozen during ACCESS, so RdM still names this load.
               if (bus.bus_ack) begin
                  state       <= ST_IDLE;
                  bus.bus_req <= 1'b0;
                  if (load_q) begin
                     ResultW   <= load_result;
                     RdW       <= RdM;
                     RegWriteW <= (RdM != 5'd0);
                  end else begin
                     RegWriteW <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  state       <= ST_IDLE;
                  bus.bus_req <= 1'b0;
                  RegWriteW   <= 1'b0;
               end else begin
                  RegWriteW <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a per-cycle expectation model built from
// the access rules, a negedge compare process and literal spot checks.
module tb_mem_access_unit;
   import riscv_mem_pkg::*;

   localparam int TO_CYCLES = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] PC_MEM, AluOutM, StoreDataM;
   logic [4:0]  RdM;
   logic [2:0]  RegWriteM;
   logic        MemToRegM, LoadNpcM;
   logic [3:0]  MemWriteM;
   logic        StallM, MisalignM, RegWriteW;
   logic [31:0] ResultW;
   logic [4:0]  RdW;
   mem_state_t  state_dbg;
`ifdef MEM_TIMEOUT_EN
   logic        BusErrM;
`endif

   mem_access_unit_if #(.ADDR_W(32)) bus_if ();

   mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clk        (clk),
      .rst        (rst),
      .PC_MEM     (PC_MEM),
      .AluOutM    (AluOutM),
      .StoreDataM (StoreDataM),
      .RdM        (RdM),
      .RegWriteM  (RegWriteM),
      .MemToRegM  (MemToRegM),
      .MemWriteM  (MemWriteM),
      .LoadNpcM   (LoadNpcM),
      .bus        (bus_if.master),
      .StallM     (StallM),
      .MisalignM  (MisalignM),
      .ResultW    (ResultW),
      .RdW        (RdW),
      .RegWriteW  (RegWriteW),
`ifdef MEM_TIMEOUT_EN
      .BusErrM    (BusErrM),
`endif
      .state_dbg  (state_dbg)
   );

   // Expected outputs for the cycle currently being observed.
   logic        exp_stall, exp_req, exp_misalign, exp_regw;
   logic [31:0] exp_result, exp_addr, exp_wdata;
   logic [4:0]  exp_rd;
   logic [3:0]  exp_we;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit check_en  = 0;
   int stall_cnt = 0;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_we;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
   endtask

   // ---------------- model ----------------
   function automatic logic [31:0] m_extend(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] lt);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (lt)
         3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic bit m_misaligned(input logic m2r, input logic [2:0] lt,
                                       input logic [3:0] mw, input logic [31:0] a);
      bit half, word;
      half = m2r ? (lt == 3'd2 || lt == 3'd5) : (mw == 4'b0011);
      word = m2r ? (lt == 3'd3) : (mw == 4'b1111);
      return (half && (a % 2 != 0)) || (word && (a % 4 != 0));
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (check_en) begin
         check("StallM", StallM, exp_stall);
         check("bus_req", bus_if.bus_req, exp_req);
         check("MisalignM", MisalignM, exp_misalign);
         check("RegWriteW", RegWriteW, exp_regw);
         if (exp_regw) begin
            check("ResultW", ResultW, exp_result);
            check("RdW", RdW, exp_rd);
         end
         if (exp_req) begin
            check("bus_addr", bus_if.bus_addr, exp_addr);
            check("bus_we", bus_if.bus_we, exp_we);
            check("bus_wdata", bus_if.bus_wdata, exp_wdata);
         end
         if (StallM) stall_cnt++;
         if (bus_if.bus_req) begin
            seen_addr  = bus_if.bus_addr;
            seen_we    = bus_if.bus_we;
            seen_wdata = bus_if.bus_wdata;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [31:0] pc, alu, sd, input logic [4:0] rd,
                        input logic [2:0] rwt, input logic m2r, input logic [3:0] mw,
                        input logic npc);
      PC_MEM = pc; AluOutM = alu; StoreDataM = sd; RdM = rd;
      RegWriteM = rwt; MemToRegM = m2r; MemWriteM = mw; LoadNpcM = npc;
   endtask

   // Called at posedge+1; returns at posedge+1 after the instruction retires.
   // n_wait = ACCESS cycle in which ack arrives (1 = zero-wait).
   task automatic do_instr(input logic [31:0] pc, alu, sd, input logic [4:0] rd,
                           input logic [2:0] rwt, input logic m2r, input logic [3:0] mw,
                           input logic npc, input int n_wait, input logic [31:0] rdata);
      logic [7:0] we_wide;
      drive(pc, alu, sd, rd, rwt, m2r, mw, npc);
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = ~rdata;
      stall_cnt = 0;
      if (!(m2r || mw != 4'd0)) begin
         exp_stall = 0;
         @(posedge clk); #1;
         exp_req = 0; exp_misalign = 0;
         exp_regw   = (rwt >= 1 && rwt <= 5 && rd != 0);
         exp_result = npc ? pc + 4 : alu;
         exp_rd     = rd;
      end else if (m_misaligned(m2r, rwt, mw, alu)) begin
         exp_stall = 0;
         @(posedge clk); #1;
         exp_req = 0; exp_misalign = 1; exp_regw = 0;
      end else begin
         exp_stall = 1;
         @(posedge clk); #1;
         we_wide = {4'd0, mw} << (alu % 4);
         exp_req = 1; exp_misalign = 0; exp_regw = 0;
         exp_addr  = alu - (alu % 4);
         exp_we    = we_wide[3:0];
         exp_wdata = sd << (8 * (alu % 4));
         for (int k = 1; k <= n_wait; k++) begin
            bus_if.bus_ack   = (k == n_wait);
            bus_if.bus_rdata = (k == n_wait) ? rdata : ~rdata;
            exp_stall = (k != n_wait);
            @(posedge clk); #1;
            exp_regw = 0;
            if (k == n_wait) begin
               exp_req = 0;
               if (m2r) begin
                  exp_regw   = (rd != 0);
                  exp_result = m_extend(rdata, alu[1:0], rwt);
                  exp_rd     = rd;
               end
            end
         end
         bus_if.bus_ack = 1'b0;
      end
   endtask

   task automatic nop();
      do_instr(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 4'd0, 1'b0, 0, 32'h0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 4'd0, 1'b0);
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_bus_req", bus_if.bus_req, 0);
      check("reset_bus_we", bus_if.bus_we, 0);
      check("reset_bus_addr", bus_if.bus_addr, 0);
      check("reset_bus_wdata", bus_if.bus_wdata, 0);
      check("reset_ResultW", ResultW, 0);
      check("reset_RdW", RdW, 0);
      check("reset_RegWriteW", RegWriteW, 0);
      check("reset_MisalignM", MisalignM, 0);
      check("reset_state", state_dbg, ST_IDLE);
      rst = 1'b0;
      exp_stall = 0; exp_req = 0; exp_misalign = 0; exp_regw = 0;
      exp_result = 0; exp_rd = 0; exp_addr = 0; exp_we = 0; exp_wdata = 0;
      check_en = 1;

      // ALU write
      do_instr(32'h0, 32'h1234, 32'h0, 5'd5, 3'd3, 1'b0, 4'd0, 1'b0, 0, 32'h0);
      check("alu_ResultW", ResultW, 32'h1234);
      check("alu_RdW", RdW, 5);
      check("alu_RegWriteW", RegWriteW, 1);
      check("alu_stall_cycles", stall_cnt, 0);
      // JAL link value, then non-writing forms
      do_instr(32'h1000, 32'h2000, 32'h0, 5'd1, 3'd3, 1'b0, 4'd0, 1'b1, 0, 32'h0);
      check("jal_ResultW", ResultW, 32'h1004);
      do_instr(32'h0, 32'h55, 32'h0, 5'd0, 3'd3, 1'b0, 4'd0, 1'b0, 0, 32'h0);
      do_instr(32'h0, 32'h66, 32'h0, 5'd7, 3'd6, 1'b0, 4'd0, 1'b0, 0, 32'h0);

      // LB at 0x103, ack in the fourth ACCESS cycle
      do_instr(32'h0, 32'h103, 32'h0, 5'd9, 3'd1, 1'b1, 4'd0, 1'b0, 4, 32'h80FF_FF7F);
      check("lb_stall_cycles", stall_cnt, 4);
      check("lb_bus_addr", seen_addr, 32'h100);
      check("lb_bus_we", seen_we, 4'b0000);
      check("lb_ResultW", ResultW, 32'hFFFF_FF80);
      do_instr(32'h0, 32'h103, 32'h0, 5'd9, 3'd4, 1'b1, 4'd0, 1'b0, 1, 32'h80FF_FF7F);
      check("lbu_ResultW", ResultW, 32'h0000_0080);
      do_instr(32'h0, 32'h100, 32'h0, 5'd10, 3'd1, 1'b1, 4'd0, 1'b0, 2, 32'h80FF_FF7F);
      do_instr(32'h0, 32'h102, 32'h0, 5'd11, 3'd2, 1'b1, 4'd0, 1'b0, 1, 32'h8001_1234);
      check("lh_ResultW", ResultW, 32'hFFFF_8001);
      do_instr(32'h0, 32'h100, 32'h0, 5'd12, 3'd5, 1'b1, 4'd0, 1'b0, 3, 32'h8001_9234);
      check("lhu_ResultW", ResultW, 32'h0000_9234);
      do_instr(32'h0, 32'h200, 32'h0, 5'd13, 3'd3, 1'b1, 4'd0, 1'b0, 2, 32'hDEAD_BEEF);

      // Stores
      do_instr(32'h0, 32'h202, 32'h0000_BEEF, 5'd0, 3'd0, 1'b0, 4'b0011, 1'b0, 1, 32'h0);
      check("sh_bus_we", seen_we, 4'b1100);
      check("sh_bus_wdata", seen_wdata, 32'hBEEF_0000);
      check("sh_stall_cycles", stall_cnt, 1);
      check("sh_RegWriteW", RegWriteW, 0);
      do_instr(32'h0, 32'h301, 32'h0000_00AB, 5'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 2, 32'h0);
      check("sb_bus_we", seen_we, 4'b0010);
      do_instr(32'h0, 32'h304, 32'h1234_5678, 5'd0, 3'd0, 1'b0, 4'b1111, 1'b0, 1, 32'h0);

      // Misaligned accesses
      do_instr(32'h0, 32'h101, 32'h0, 5'd14, 3'd3, 1'b1, 4'd0, 1'b0, 1, 32'h0);
      check("lw_mis_MisalignM", MisalignM, 1);
      check("lw_mis_stall_cycles", stall_cnt, 0);
      do_instr(32'h0, 32'h203, 32'h1, 5'd0, 3'd0, 1'b0, 4'b0011, 1'b0, 1, 32'h0);
      do_instr(32'h0, 32'h101, 32'h0, 5'd15, 3'd5, 1'b1, 4'd0, 1'b0, 1, 32'h0);
      nop();

      // Load to x0 still reads the bus
      do_instr(32'h0, 32'h400, 32'h0, 5'd0, 3'd3, 1'b1, 4'd0, 1'b0, 2, 32'h1111_2222);
      check("ld_x0_stall_cycles", stall_cnt, 2);

      // Reset two cycles into ACCESS, ack arriving afterwards
      drive(32'h0, 32'h40, 32'h0, 5'd3, 3'd3, 1'b1, 4'd0, 1'b0);
      exp_stall = 1;
      @(posedge clk); #1;
      exp_req = 1; exp_regw = 0; exp_misalign = 0;
      exp_addr = 32'h40; exp_we = 4'b0000; exp_wdata = 32'h0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_req = 0; exp_regw = 0; exp_misalign = 0;
      rst = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 4'd0, 1'b0);
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
      exp_stall = 0;
      check("rst_state", state_dbg, ST_IDLE);
      check("rst_bus_we", bus_if.bus_we, 0);
      check("rst_bus_addr", bus_if.bus_addr, 0);
      check("rst_ResultW", ResultW, 0);
      check("rst_RdW", RdW, 0);
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      check("late_ack_state", state_dbg, ST_IDLE);
      check("late_ack_bus_req", bus_if.bus_req, 0);
      nop();

`ifdef MEM_TIMEOUT_EN
      // Ack never arrives: watchdog aborts after TO_CYCLES ACCESS cycles
      drive(32'h0, 32'h500, 32'h0, 5'd4, 3'd3, 1'b1, 4'd0, 1'b0);
      stall_cnt = 0;
      exp_stall = 1;
      @(posedge clk); #1;
      exp_req = 1; exp_addr = 32'h500; exp_we = 4'b0000; exp_wdata = 32'h0;
      for (int k = 1; k <= TO_CYCLES; k++) begin
         exp_stall = (k != TO_CYCLES);
         @(posedge clk); #1;
         if (k == TO_CYCLES) exp_req = 0;
      end
      check("to_BusErrM", BusErrM, 1);
      check("to_stall_cycles", stall_cnt, TO_CYCLES);
      nop();
      check("to_BusErrM_pulse", BusErrM, 0);
`endif

      @(negedge clk);
      check_en = 0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
